// File: rtl/serializer_link_arbiter_pkg.sv
// Shared definitions for the flit-to-phit serializer arbiter:
// state encoding, default widths and the clog2 helper.
package serializer_link_arbiter_pkg;

  localparam int INPUT_SIZE_DEF  = 32;
  localparam int OUTPUT_SIZE_DEF = 4;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_LOAD = 2'd1;
  localparam logic [1:0] ENC_SER  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_LOAD = ENC_LOAD,
    ST_SER  = ENC_SER
  } state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

  // Flit width must be an exact multiple of the phit width.
  function automatic int phit_number(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/serializer_link_arbiter_if.sv
// Link-side bundle: FIFO empties and link ready in, pop/select/serializer
// controls out. master = arbiter, slave = FIFOs/datapath/environment.
interface serializer_link_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = (NUM_PORTS > 1) ? serializer_link_arbiter_pkg::clog2(NUM_PORTS) : 1
);
  logic [NUM_PORTS-1:0] fifo_empty;
  logic                 link_ready;
  logic [NUM_PORTS-1:0] read_fifo;
  logic [SEL_W-1:0]     grant_sel;
  logic                 shift_register_load;
  logic                 shift_enable;
  logic                 phit_valid;
  logic                 last_phit;
  logic                 serializer_idle;

  modport master (
    input  fifo_empty, link_ready,
    output read_fifo, grant_sel, shift_register_load, shift_enable,
           phit_valid, last_phit, serializer_idle
  );

  modport slave (
    output fifo_empty, link_ready,
    input  read_fifo, grant_sel, shift_register_load, shift_enable,
           phit_valid, last_phit, serializer_idle
  );
endinterface

// File: rtl/serializer_link_arbiter_rr.sv
// Combinational round-robin picker: search starts one past the pointer,
// so the port served last has the lowest priority.
module rr_arbiter
  import serializer_link_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt_oh,
  output logic [SEL_W-1:0]     gnt_enc,
  output logic                 gnt_valid
);

  // First requester found walking ptr+1, ptr+2, ... wrapping at NUM_PORTS.
  always_comb begin
    logic [SEL_W-1:0] idx;
    gnt_oh    = '0;
    gnt_enc   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = SEL_W'((int'(ptr) + i) % NUM_PORTS);
      if (!gnt_valid && req[idx]) begin
        gnt_valid    = 1'b1;
        gnt_oh[idx]  = 1'b1;
        gnt_enc      = idx;
      end
    end
  end

endmodule

// File: rtl/serializer_link_arbiter.sv
// Shares one flit serializer between NUM_PORTS flit FIFOs. IDLE picks a
// port, LOAD pops it into the shift register for one cycle, SER walks the
// phits out one per accepted link cycle and chains straight into the next
// LOAD when another port is waiting.
module serializer_link_arbiter
  import serializer_link_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
  parameter int OUTPUT_SIZE = OUTPUT_SIZE_DEF
) (
  input logic                         clk,
  input logic                         reset,
  serializer_link_arbiter_if.master   lnk
);

  localparam int PHIT_NUMBER = phit_number(INPUT_SIZE, OUTPUT_SIZE);
  localparam int SEL_W       = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
  localparam int CNT_W       = (PHIT_NUMBER > 1) ? clog2(PHIT_NUMBER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHIT_NUMBER - 1);

  state_t               state;
  logic [SEL_W-1:0]     ptr;
  logic [CNT_W-1:0]     cnt;
  logic [SEL_W-1:0]     grant_sel;
  logic [NUM_PORTS-1:0] read_fifo;
  logic                 load;
  logic                 phit_valid;
  logic                 last_phit;
  logic                 idle;

  logic [NUM_PORTS-1:0] gnt_oh;
  logic [SEL_W-1:0]     gnt_enc;
  logic                 gnt_valid;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .SEL_W(SEL_W)) u_rr (
    .req       (~lnk.fifo_empty),
    .ptr       (ptr),
    .gnt_oh    (gnt_oh),
    .gnt_enc   (gnt_enc),
    .gnt_valid (gnt_valid)
  );

  // Controller FSM with registered outputs; pointer moves to the served
  // port in LOAD so that port drops to lowest priority for the next pick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= SEL_W'(NUM_PORTS - 1);
      cnt        <= '0;
      grant_sel  <= '0;
      read_fifo  <= '0;
      load       <= 1'b0;
      phit_valid <= 1'b0;
      last_phit  <= 1'b0;
      idle       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            state     <= ST_LOAD;
            grant_sel <= gnt_enc;
            read_fifo <= gnt_oh;
            load      <= 1'b1;
            idle      <= 1'b0;
          end
        end
        ST_LOAD: begin
          state      <= ST_SER;
          ptr        <= grant_sel;
          cnt        <= '0;
          read_fifo  <= '0;
          load       <= 1'b0;
          phit_valid <= 1'b1;
          last_phit  <= (PHIT_NUMBER == 1);
        end
        ST_SER: begin
          // link_ready low: counter and shift register hold.
          if (lnk.link_ready) begin
            if (cnt == CNT_LAST) begin
              phit_valid <= 1'b0;
              last_phit  <= 1'b0;
              if (gnt_valid) begin
                state     <= ST_LOAD;
                grant_sel <= gnt_enc;
                read_fifo <= gnt_oh;
                load      <= 1'b1;
              end else begin
                state <= ST_IDLE;
                idle  <= 1'b1;
              end
            end else begin
              cnt       <= cnt + CNT_W'(1);
              last_phit <= ((cnt + CNT_W'(1)) == CNT_LAST);
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          read_fifo  <= '0;
          load       <= 1'b0;
          phit_valid <= 1'b0;
          last_phit  <= 1'b0;
          idle       <= 1'b1;
        end
      endcase
    end
  end

  // Only shift_enable sees link_ready combinationally.
  assign lnk.shift_enable        = (state == ST_SER) && lnk.link_ready;
  assign lnk.read_fifo           = read_fifo;
  assign lnk.grant_sel           = grant_sel;
  assign lnk.shift_register_load = load;
  assign lnk.phit_valid          = phit_valid;
  assign lnk.last_phit           = last_phit;
  assign lnk.serializer_idle     = idle;

endmodule

// File: tb/tb_serializer_link_arbiter.sv
// Directed bench for serializer_link_arbiter: FIFO occupancy model drives
// fifo_empty, expected grant ports are queued with the stimulus and
// checked against each read_fifo pulse.
module tb_serializer_link_arbiter;
  localparam int NP = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   occ [NP];
  int   exp_q[$];
  int   pop_cyc[$];
  int   cyc = 0, errors = 0, checks = 0, phit_cnt = 0;
  int   acc, stall, c;

  serializer_link_arbiter_if #(.NUM_PORTS(NP)) bus ();

  serializer_link_arbiter #(.NUM_PORTS(NP), .INPUT_SIZE(32), .OUTPUT_SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .lnk   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb
    for (int i = 0; i < NP; i++) bus.fifo_empty[i] = (occ[i] == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every pop must match the next queued port.
  always @(negedge clk) begin
    if (!reset) phit_cnt = 0;
    else begin
      if (bus.read_fifo != '0) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 32'(bus.read_fifo), 32'd0);
        else begin
          int e;
          e = exp_q.pop_front();
          chk("pop_onehot", 32'(bus.read_fifo), 32'(1 << e));
          chk("pop_grant_sel", 32'(bus.grant_sel), 32'(e));
          chk("pop_nonempty", 32'(occ[e] > 0), 32'd1);
          pop_cyc.push_back(cyc);
        end
        for (int i = 0; i < NP; i++)
          if (bus.read_fifo[i] && occ[i] > 0) occ[i]--;
      end
      if (bus.phit_valid && bus.link_ready) begin
        phit_cnt++;
        if (bus.last_phit) begin
          chk("phits_per_flit", 32'(phit_cnt), 32'd8);
          phit_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.serializer_idle && exp_q.size() == 0) && n < 300);
    chk(tag, 32'(bus.serializer_idle && exp_q.size() == 0), 32'd1);
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.shift_register_load && n < 50);
    chk(tag, 32'(bus.shift_register_load), 32'd1);
  endtask

  initial begin
    bus.link_ready = 1'b1;
    for (int i = 0; i < NP; i++) occ[i] = 1;

    // Reset held with every FIFO non-empty: nothing may move.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_read_fifo", 32'(bus.read_fifo), 32'd0);
      chk("rst_load", 32'(bus.shift_register_load), 32'd0);
      chk("rst_shift_en", 32'(bus.shift_enable), 32'd0);
      chk("rst_phit_valid", 32'(bus.phit_valid), 32'd0);
      chk("rst_last_phit", 32'(bus.last_phit), 32'd0);
      chk("rst_idle", 32'(bus.serializer_idle), 32'd1);
      chk("rst_grant_sel", 32'(bus.grant_sel), 32'd0);
    end
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    reset = 1'b1;
    @(negedge clk);
    chk("first_grant_port0", 32'(bus.grant_sel), 32'd0);
    chk("first_load", 32'(bus.shift_register_load), 32'd1);
    wait_idle("rst_release_done");

    // Fairness: two flits per port, strict 0,1,2,3 rotation, 9 cycles apart.
    pop_cyc.delete();
    for (int i = 0; i < NP; i++) occ[i] = 2;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) exp_q.push_back(p);
    wait_idle("fair_done");
    chk("fair_pop_count", 32'(pop_cyc.size()), 32'd8);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("fair_period", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd9);

    // Single flit from port 2.
    @(negedge clk);
    occ[2] = 1; exp_q.push_back(2);
    chk("single_idle_before", 32'(bus.serializer_idle), 32'd1);
    @(negedge clk);
    chk("single_load", 32'(bus.shift_register_load), 32'd1);
    chk("single_read", 32'(bus.read_fifo), 32'b0100);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("single_phit_valid", 32'(bus.phit_valid), 32'd1);
      chk("single_last_phit", 32'(bus.last_phit), 32'(k == 7));
      chk("single_read_quiet", 32'(bus.read_fifo), 32'd0);
    end
    @(negedge clk);
    chk("single_idle_after", 32'(bus.serializer_idle), 32'd1);
    chk("single_valid_after", 32'(bus.phit_valid), 32'd0);

    // Stall 5 cycles while the counter sits at phit 3.
    occ[1] = 1; exp_q.push_back(1);
    wait_load("stall_load");
    acc = 0; stall = 0; c = 0;
    while (acc < 8 && c < 40) begin
      @(negedge clk); c++;
      chk("stall_phit_valid", 32'(bus.phit_valid), 32'd1);
      if (bus.link_ready) begin
        chk("stall_shift_en_on", 32'(bus.shift_enable), 32'd1);
        chk("stall_last_phit", 32'(bus.last_phit), 32'(acc == 7));
        acc++;
      end else begin
        chk("stall_shift_en_off", 32'(bus.shift_enable), 32'd0);
        chk("stall_last_hold", 32'(bus.last_phit), 32'd0);
      end
      if (acc == 3 && stall < 5) begin bus.link_ready = 1'b0; stall++; end
      else bus.link_ready = 1'b1;
    end
    chk("stall_cycles", 32'(c), 32'd13);
    @(negedge clk);
    chk("stall_idle_after", 32'(bus.serializer_idle), 32'd1);

    // Reset while port 0's flit is at phit 5.
    occ[0] = 1; exp_q.push_back(0);
    wait_load("mid_rst_load");
    acc = 0; c = 0;
    while (acc < 5 && c < 20) begin
      @(negedge clk); c++;
      if (bus.phit_valid && bus.link_ready) acc++;
    end
    @(negedge clk);
    chk("mid_rst_at_phit5", 32'(bus.phit_valid), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_idle", 32'(bus.serializer_idle), 32'd1);
    chk("mid_rst_valid", 32'(bus.phit_valid), 32'd0);
    chk("mid_rst_last", 32'(bus.last_phit), 32'd0);
    chk("mid_rst_read", 32'(bus.read_fifo), 32'd0);
    chk("mid_rst_grant_sel", 32'(bus.grant_sel), 32'd0);
    occ[0] = 1; occ[2] = 1;
    exp_q.push_back(0); exp_q.push_back(2);
    @(negedge clk);
    chk("mid_rst_no_pop", 32'(bus.read_fifo), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_fresh_port0", 32'(bus.grant_sel), 32'd0);
    chk("mid_rst_fresh_load", 32'(bus.shift_register_load), 32'd1);
    wait_idle("mid_rst_done");

    // Back-to-back: port 1 appears during port 0's last accepted phit.
    occ[0] = 1; exp_q.push_back(0);
    wait_load("b2b_load0");
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.last_phit && c < 20);
    chk("b2b_last_seen", 32'(bus.last_phit), 32'd1);
    occ[1] = 1; exp_q.push_back(1);
    @(negedge clk);
    chk("b2b_load1", 32'(bus.shift_register_load), 32'd1);
    chk("b2b_not_idle", 32'(bus.serializer_idle), 32'd0);
    chk("b2b_grant_sel", 32'(bus.grant_sel), 32'd1);
    wait_idle("b2b_done");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
